// File: rtl/rob_commit_ctrl_pkg.sv
// rtl/rob_commit_ctrl_pkg.sv - shared widths, ROB entry layout and mispredict helper
package rob_commit_ctrl_pkg;

   localparam int ROB_SIZE = 16;
   localparam int ROB_W    = 4;
   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_rd;
      logic [REG_W-1:0]  rd;
      logic              is_br;
      logic              pred_taken;
      logic              taken;
      logic [DATA_W-1:0] val;
      logic [DATA_W-1:0] alt_pc;
   } rob_entry_t;

   // A branch whose resolved direction disagrees with the prediction
   function automatic logic is_mispredict(input rob_entry_t e);
      return e.is_br && (e.taken != e.pred_taken);
   endfunction

endpackage

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - reorder buffer with in-order commit and mispredict flush
module rob_commit_ctrl
   import rob_commit_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   input  logic              issue_valid,
   input  logic              issue_has_rd,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic              issue_is_br,
   input  logic              issue_pred_taken,
   input  logic [DATA_W-1:0] issue_alt_pc,
   output logic              full,
   output logic [ROB_W-1:0]  alloc_robpos,
   output logic              lock,
   output logic [REG_W-1:0]  lock_rd,
   output logic [ROB_W-1:0]  lock_robpos,
   input  logic              wb_valid,
   input  logic [ROB_W-1:0]  wb_robpos,
   input  logic [DATA_W-1:0] wb_val,
   input  logic              wb_taken,
   input  logic [ROB_W-1:0]  rs1_q_robpos,
   input  logic [ROB_W-1:0]  rs2_q_robpos,
   output logic              rs1_q_ready,
   output logic              rs2_q_ready,
   output logic [DATA_W-1:0] rs1_q_val,
   output logic [DATA_W-1:0] rs2_q_val,
   output logic              unlock,
   output logic [REG_W-1:0]  unlock_rd,
   output logic [ROB_W-1:0]  unlock_robpos,
   output logic [DATA_W-1:0] unlock_val,
   output logic              clear,
   output logic [DATA_W-1:0] redirect_pc
);

   rob_entry_t        r_rob [ROB_SIZE];
   logic [ROB_W-1:0]  r_head;
   logic [ROB_W-1:0]  r_tail;
   logic [ROB_W:0]    r_count;
   logic              r_unlock;
   logic [REG_W-1:0]  r_unlock_rd;
   logic [ROB_W-1:0]  r_unlock_robpos;
   logic [DATA_W-1:0] r_unlock_val;
   logic              r_clear;
   logic [DATA_W-1:0] r_redirect_pc;

   logic              w_full;
   logic              w_alloc;
   logic              w_wb;
   logic              w_commit;
   rob_entry_t        w_head_e;

   // full is judged on the pre-commit count, so a commit never frees a slot in its own cycle
   assign w_full   = (r_count == (ROB_W+1)'(ROB_SIZE));
   assign w_alloc  = ready && issue_valid && !w_full && !r_clear;
   assign w_wb     = ready && wb_valid && !r_clear && r_rob[wb_robpos].valid;
   assign w_head_e = r_rob[r_head];
   assign w_commit = ready && !r_clear && w_head_e.valid && w_head_e.done;

   assign full          = w_full;
   assign alloc_robpos  = r_tail;
   assign lock          = w_alloc && issue_has_rd && (issue_rd != '0);
   assign lock_rd       = issue_rd;
   assign lock_robpos   = r_tail;
   assign unlock        = r_unlock;
   assign unlock_rd     = r_unlock_rd;
   assign unlock_robpos = r_unlock_robpos;
   assign unlock_val    = r_unlock_val;
   assign clear         = r_clear;
   assign redirect_pc   = r_redirect_pc;

   // Operand query port 1: stored result first, then same-cycle CDB bypass
   always_comb begin
      rs1_q_ready = 1'b0;
      rs1_q_val   = '0;
      if (!r_clear) begin
         if (r_rob[rs1_q_robpos].valid && r_rob[rs1_q_robpos].done) begin
            rs1_q_ready = 1'b1;
            rs1_q_val   = r_rob[rs1_q_robpos].val;
         end else if (wb_valid && (wb_robpos == rs1_q_robpos)) begin
            rs1_q_ready = 1'b1;
            rs1_q_val   = wb_val;
         end
      end
   end

   // Operand query port 2: identical lookup for the second source operand
   always_comb begin
      rs2_q_ready = 1'b0;
      rs2_q_val   = '0;
      if (!r_clear) begin
         if (r_rob[rs2_q_robpos].valid && r_rob[rs2_q_robpos].done) begin
            rs2_q_ready = 1'b1;
            rs2_q_val   = r_rob[rs2_q_robpos].val;
         end else if (wb_valid && (wb_robpos == rs2_q_robpos)) begin
            rs2_q_ready = 1'b1;
            rs2_q_val   = wb_val;
         end
      end
   end

   // Allocate, writeback, in-order commit and mispredict flush; flush overrides everything else
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_unlock        <= 1'b0;
         r_unlock_rd     <= '0;
         r_unlock_robpos <= '0;
         r_unlock_val    <= '0;
         r_clear         <= 1'b0;
         r_redirect_pc   <= '0;
         for (int i = 0; i < ROB_SIZE; i++) r_rob[i].valid <= 1'b0;
      end else if (!ready) begin
         r_unlock <= 1'b0;
         r_clear  <= 1'b0;
      end else begin
         r_unlock <= 1'b0;
         r_clear  <= 1'b0;
         if (w_alloc) begin
            r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0, has_rd: issue_has_rd,
                               rd: issue_rd, is_br: issue_is_br,
                               pred_taken: issue_pred_taken, taken: 1'b0,
                               val: '0, alt_pc: issue_alt_pc};
            r_tail <= r_tail + 1'b1;
         end
         if (w_wb) begin
            r_rob[wb_robpos].done  <= 1'b1;
            r_rob[wb_robpos].val   <= wb_val;
            r_rob[wb_robpos].taken <= wb_taken;
         end
         if (w_commit) begin
            r_unlock            <= w_head_e.has_rd && (w_head_e.rd != '0);
            r_unlock_rd         <= w_head_e.rd;
            r_unlock_robpos     <= r_head;
            r_unlock_val        <= w_head_e.val;
            r_rob[r_head].valid <= 1'b0;
            r_head              <= r_head + 1'b1;
         end
         r_count <= r_count + (ROB_W+1)'(w_alloc) - (ROB_W+1)'(w_commit);
         if (w_commit && is_mispredict(w_head_e)) begin
            r_clear       <= 1'b1;
            r_redirect_pc <= w_head_e.alt_pc;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int i = 0; i < ROB_SIZE; i++) r_rob[i].valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - directed vector bench for rob_commit_ctrl
module tb_rob_commit_ctrl;
   import rob_commit_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              reset, ready;
   logic              issue_valid, issue_has_rd, issue_is_br, issue_pred_taken;
   logic [REG_W-1:0]  issue_rd;
   logic [DATA_W-1:0] issue_alt_pc;
   logic              full, lock, unlock, clear;
   logic [ROB_W-1:0]  alloc_robpos, lock_robpos, unlock_robpos;
   logic [REG_W-1:0]  lock_rd, unlock_rd;
   logic              wb_valid, wb_taken;
   logic [ROB_W-1:0]  wb_robpos, rs1_q_robpos, rs2_q_robpos;
   logic [DATA_W-1:0] wb_val, rs1_q_val, rs2_q_val, unlock_val, redirect_pc;
   logic              rs1_q_ready, rs2_q_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rob_commit_ctrl dut (
      .clk(clk), .reset(reset), .ready(ready),
      .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
      .issue_is_br(issue_is_br), .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
      .full(full), .alloc_robpos(alloc_robpos), .lock(lock), .lock_rd(lock_rd),
      .lock_robpos(lock_robpos), .wb_valid(wb_valid), .wb_robpos(wb_robpos),
      .wb_val(wb_val), .wb_taken(wb_taken),
      .rs1_q_robpos(rs1_q_robpos), .rs2_q_robpos(rs2_q_robpos),
      .rs1_q_ready(rs1_q_ready), .rs2_q_ready(rs2_q_ready),
      .rs1_q_val(rs1_q_val), .rs2_q_val(rs2_q_val),
      .unlock(unlock), .unlock_rd(unlock_rd), .unlock_robpos(unlock_robpos),
      .unlock_val(unlock_val), .clear(clear), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic iv, hrd; logic [4:0] rd; logic br, pt; logic [31:0] alt;
      logic wv; logic [3:0] wtag; logic [31:0] wval; logic wtk;
      logic rdy; logic [3:0] q1, q2;
      logic e_lk; logic [3:0] e_lpos;
      logic e_q1r; logic [31:0] e_q1v; logic e_q2r; logic [31:0] e_q2v;
      logic e_unl; logic [4:0] e_urd; logic [3:0] e_upos; logic [31:0] e_uval;
      logic e_clr; logic [31:0] e_rpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic iv, hrd, input logic [4:0] rd, input logic br, pt, input logic [31:0] alt,
      input logic wv, input logic [3:0] wtag, input logic [31:0] wval, input logic wtk,
      input logic rdy, input logic [3:0] q1, q2,
      input logic e_lk, input logic [3:0] e_lpos,
      input logic e_q1r, input logic [31:0] e_q1v, input logic e_q2r, input logic [31:0] e_q2v,
      input logic e_unl, input logic [4:0] e_urd, input logic [3:0] e_upos,
      input logic [31:0] e_uval, input logic e_clr, input logic [31:0] e_rpc);
      vec_t v;
      v = '{iv, hrd, rd, br, pt, alt, wv, wtag, wval, wtk, rdy, q1, q2, e_lk, e_lpos,
            e_q1r, e_q1v, e_q2r, e_q2v, e_unl, e_urd, e_upos, e_uval, e_clr, e_rpc};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      ready = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
      issue_is_br = 1'b0; issue_pred_taken = 1'b0; issue_alt_pc = '0;
      wb_valid = 1'b0; wb_robpos = '0; wb_val = '0; wb_taken = 1'b0;
      rs1_q_robpos = 4'd15; rs2_q_robpos = 4'd15;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = rd;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_full", 32'(full), 0);
      chk("rst_lockpos", 32'(lock_robpos), 0);
      chk("rst_unlock", 32'(unlock), 0);
      chk("rst_unlock_val", unlock_val, 0);
      chk("rst_clear", 32'(clear), 0);
      chk("rst_redirect", redirect_pc, 0);

      //        iv hrd rd br pt alt     wv tag wval wtk rdy q1 q2 | lk lpos q1r q1v q2r q2v | unl urd upos uval clr rpc
      tbl.push_back(mk(1,1,5,0,0,0,     0,0,0,0,      1,15,15, 1,0, 0,0,0,0,           0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     1,0,'h1234,0, 1,0,15,  0,1, 1,'h1234,0,0,      0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,0,15,  0,1, 1,'h1234,0,0,      1,5,0,'h1234,0,0));
      tbl.push_back(mk(1,1,1,0,0,0,     0,0,0,0,      1,15,15, 1,1, 0,0,0,0,           0,5,0,'h1234,0,0));
      tbl.push_back(mk(1,1,2,0,0,0,     0,0,0,0,      1,15,15, 1,2, 0,0,0,0,           0,5,0,'h1234,0,0));
      tbl.push_back(mk(1,1,0,0,0,0,     0,0,0,0,      1,15,15, 0,3, 0,0,0,0,           0,5,0,'h1234,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     1,3,'h33,0,   1,3,15,  0,4, 1,'h33,0,0,        0,5,0,'h1234,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     1,1,'h11,0,   1,2,15,  0,4, 0,0,0,0,           0,5,0,'h1234,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     1,2,'h22,0,   1,3,15,  0,4, 1,'h33,0,0,        1,1,1,'h11,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,15,15, 0,4, 0,0,0,0,           1,2,2,'h22,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,15,15, 0,4, 0,0,0,0,           0,0,3,'h33,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h80,  0,0,0,0,      1,15,15, 0,4, 0,0,0,0,           0,0,3,'h33,0,0));
      tbl.push_back(mk(1,1,7,0,0,0,     0,0,0,0,      1,15,15, 1,5, 0,0,0,0,           0,0,3,'h33,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     1,4,0,1,      1,15,15, 0,6, 0,0,0,0,           0,0,3,'h33,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,15,15, 0,6, 0,0,0,0,           0,0,4,0,1,'h80));
      tbl.push_back(mk(1,1,9,0,0,0,     1,5,'h55,0,   1,5,15,  0,0, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     1,5,'h55,0,   1,5,15,  0,0, 1,'h55,0,0,        0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,5,15,  0,0, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(1,1,3,0,0,0,     0,0,0,0,      1,15,15, 1,0, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(1,1,4,0,0,0,     0,0,0,0,      1,15,15, 1,1, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(1,1,6,0,0,0,     0,0,0,0,      1,15,15, 1,2, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     1,2,'hAA,0,   1,2,15,  0,3, 1,'hAA,0,0,        0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,2,1,   0,3, 1,'hAA,0,0,        0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     1,0,'h10,0,   1,15,15, 0,3, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(1,1,8,0,0,0,     0,0,0,0,      0,15,15, 0,3, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      0,15,15, 0,3, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      0,15,15, 0,3, 0,0,0,0,           0,0,4,0,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,15,15, 0,3, 0,0,0,0,           1,3,0,'h10,0,'h80));
      tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,      1,15,15, 0,3, 0,0,0,0,           0,3,0,'h10,0,'h80));

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         ready = tbl[k].rdy;
         issue_valid = tbl[k].iv; issue_has_rd = tbl[k].hrd; issue_rd = tbl[k].rd;
         issue_is_br = tbl[k].br; issue_pred_taken = tbl[k].pt; issue_alt_pc = tbl[k].alt;
         wb_valid = tbl[k].wv; wb_robpos = tbl[k].wtag; wb_val = tbl[k].wval; wb_taken = tbl[k].wtk;
         rs1_q_robpos = tbl[k].q1; rs2_q_robpos = tbl[k].q2;
         #1;
         chk($sformatf("v%0d_lock", k), 32'(lock), 32'(tbl[k].e_lk));
         chk($sformatf("v%0d_lockpos", k), 32'(lock_robpos), 32'(tbl[k].e_lpos));
         chk($sformatf("v%0d_q1rdy", k), 32'(rs1_q_ready), 32'(tbl[k].e_q1r));
         chk($sformatf("v%0d_q1val", k), rs1_q_val, tbl[k].e_q1v);
         chk($sformatf("v%0d_q2rdy", k), 32'(rs2_q_ready), 32'(tbl[k].e_q2r));
         chk($sformatf("v%0d_q2val", k), rs2_q_val, tbl[k].e_q2v);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_unlock", k), 32'(unlock), 32'(tbl[k].e_unl));
         chk($sformatf("v%0d_unlock_rd", k), 32'(unlock_rd), 32'(tbl[k].e_urd));
         chk($sformatf("v%0d_unlock_pos", k), 32'(unlock_robpos), 32'(tbl[k].e_upos));
         chk($sformatf("v%0d_unlock_val", k), unlock_val, tbl[k].e_uval);
         chk($sformatf("v%0d_clear", k), 32'(clear), 32'(tbl[k].e_clr));
         chk($sformatf("v%0d_redirect", k), redirect_pc, tbl[k].e_rpc);
      end

      // Fill to capacity, refuse at full, then commit-while-full and wrap the tail
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
         issue(5'(i + 1));
         #1;
         chk($sformatf("fill%0d_lock", i), 32'(lock), 1);
         chk($sformatf("fill%0d_pos", i), 32'(lock_robpos), 32'(i));
         chk($sformatf("fill%0d_full", i), 32'(full), 0);
         @(negedge clk);
      end
      issue(5'd20);
      #1;
      chk("full_set", 32'(full), 1);
      chk("full_lock", 32'(lock), 0);
      @(negedge clk);
      chk("full_tail_held", 32'(lock_robpos), 0);
      chk("full_still", 32'(full), 1);
      idle_inputs();
      wb_valid = 1'b1; wb_robpos = 4'd0; wb_val = 32'h99;
      @(negedge clk);
      chk("full_no_commit_yet", 32'(unlock), 0);
      wb_robpos = 4'd1; wb_val = 32'h98;
      issue(5'd21);
      #1;
      chk("commit_full_lock", 32'(lock), 0);
      chk("commit_full_full", 32'(full), 1);
      @(posedge clk);
      #1;
      chk("commit0_unlock", 32'(unlock), 1);
      chk("commit0_pos", 32'(unlock_robpos), 0);
      chk("commit0_val", unlock_val, 32'h99);
      @(negedge clk);
      wb_valid = 1'b0;
      issue(5'd22);
      #1;
      chk("wrap_full", 32'(full), 0);
      chk("wrap_lock", 32'(lock), 1);
      chk("wrap_pos", 32'(lock_robpos), 0);
      @(posedge clk);
      #1;
      chk("commit1_unlock", 32'(unlock), 1);
      chk("commit1_pos", 32'(unlock_robpos), 1);
      chk("commit1_val", unlock_val, 32'h98);
      @(negedge clk);
      issue(5'd23);
      #1;
      chk("refill_full", 32'(full), 0);
      chk("refill_lock", 32'(lock), 1);
      chk("refill_pos", 32'(lock_robpos), 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("refill_full_again", 32'(full), 1);
      chk("refill_tail", 32'(lock_robpos), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
